// File: rtl/rect_finder_pkg.sv
// Shared types and matrix bit-layout helper for the rectangle finder and flip stages.
package rect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Column-major flattening with (0,0) at the MSB.
    function automatic int unsigned bit_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned rows,
        input int unsigned cols
    );
        return rows * cols - 1 - (c * rows + r);
    endfunction

endpackage

// File: rtl/rect_finder_scan_ctr.sv
// Candidate rectangle counter: steps (r1,r2,c1,c2) through every row pair x column pair.
module rect_scan_ctr
    import rect_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_adv,
    output logic [RW-1:0] o_r1,
    output logic [RW-1:0] o_r2,
    output logic [CW-1:0] o_c1,
    output logic [CW-1:0] o_c2,
    output logic          o_last
);

    localparam logic [RW-1:0] R_PEN  = RW'(ROWS - 2);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_PEN  = CW'(COLS - 2);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    logic [RW-1:0] r_r1, r_r2;
    logic [CW-1:0] r_c1, r_c2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1 <= '0;
            r_r2 <= RW'(1);
            r_c1 <= '0;
            r_c2 <= CW'(1);
        end else if (i_load) begin
            r_r1 <= '0;
            r_r2 <= RW'(1);
            r_c1 <= '0;
            r_c2 <= CW'(1);
        end else if (i_adv) begin
            // Innermost index that can still step increments; every index inside it reloads to outer+1.
            if (r_c2 < C_LAST) begin
                r_c2 <= r_c2 + CW'(1);
            end else if (r_c1 < C_PEN) begin
                r_c1 <= r_c1 + CW'(1);
                r_c2 <= r_c1 + CW'(1) + CW'(1);
            end else if (r_r2 < R_LAST) begin
                r_r2 <= r_r2 + RW'(1);
                r_c1 <= '0;
                r_c2 <= CW'(1);
            end else if (r_r1 < R_PEN) begin
                r_r1 <= r_r1 + RW'(1);
                r_r2 <= r_r1 + RW'(1) + RW'(1);
                r_c1 <= '0;
                r_c2 <= CW'(1);
            end
        end
    end

    assign o_r1   = r_r1;
    assign o_r2   = r_r2;
    assign o_c1   = r_c1;
    assign o_c2   = r_c2;
    assign o_last = (r_r1 == R_PEN) && (r_r2 == R_LAST) && (r_c1 == C_PEN) && (r_c2 == C_LAST);

endmodule

// File: rtl/rect_finder.sv
// Finds the first checkerboard rectangle in a binary matrix, one candidate per cycle.
module rect_finder
    import rect_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] m_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 found,
    output logic [RW-1:0]        r1,
    output logic [RW-1:0]        r2,
    output logic [CW-1:0]        c1,
    output logic [CW-1:0]        c2,
    output logic [ROWS*COLS-1:0] m_out
);

    localparam int unsigned IDXW = $clog2(ROWS * COLS);

    state_t r_state, w_next;

    logic [ROWS*COLS-1:0] r_mat;
    logic                 r_found;
    logic [RW-1:0]        r_r1, r_r2;
    logic [CW-1:0]        r_c1, r_c2;

    logic                 w_load, w_adv, w_hit, w_miss;
    logic [RW-1:0]        w_r1, w_r2;
    logic [CW-1:0]        w_c1, w_c2;
    logic                 w_last, w_match;
    logic                 w_grid [ROWS][COLS];

    rect_scan_ctr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_r1   (w_r1),
        .o_r2   (w_r2),
        .o_c1   (w_c1),
        .o_c2   (w_c2),
        .o_last (w_last)
    );

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                w_grid[r][c] = r_mat[IDXW'(bit_idx(r, c, ROWS, COLS))];
            end
        end
    end

    assign w_match = (w_grid[w_r1][w_c1] == w_grid[w_r2][w_c2]) &&
                     (w_grid[w_r1][w_c2] == w_grid[w_r2][w_c1]) &&
                     (w_grid[w_r1][w_c1] != w_grid[w_r1][w_c2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_hit  = 1'b0;
        w_miss = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = SCAN;
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_hit  = 1'b1;
                    w_next = DONE;
                end else if (w_last) begin
                    w_miss = 1'b1;
                    w_next = DONE;
                end else begin
                    w_adv = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat   <= '0;
            r_found <= 1'b0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
        end else begin
            if (w_load) r_mat <= m_in;
            if (w_hit) begin
                r_found <= 1'b1;
                r_r1    <= w_r1;
                r_r2    <= w_r2;
                r_c1    <= w_c1;
                r_c2    <= w_c2;
            end else if (w_miss) begin
                r_found <= 1'b0;
                r_r1    <= '0;
                r_r2    <= '0;
                r_c1    <= '0;
                r_c2    <= '0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign found     = r_found;
    assign r1        = r_r1;
    assign r2        = r_r2;
    assign c1        = r_c1;
    assign c2        = r_c2;
    assign m_out     = r_mat;

endmodule
